// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one small result FIFO per functional unit, drained
// round-robin onto a single registered tag/value broadcast.
module cdb_arbiter #(
    parameter int FU_ARRAY   = 3,
    parameter int FU_SIZE    = 2,
    parameter int AR_SIZE    = 7,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [FU_ARRAY-1:0]         fu_valid_in,
    input  logic [FU_ARRAY*AR_SIZE-1:0] fu_tag_in,
    input  logic [FU_ARRAY*32-1:0]      fu_value_in,
    output logic [FU_ARRAY-1:0]         fu_ready_out,
    input  logic                        cdb_hold_in,
    input  logic                        flush_in,
    output logic                        cdb_valid_out,
    output logic [AR_SIZE-1:0]          reg_tag_out,
    output logic [31:0]                 reg_value_out,
    output logic [FU_SIZE-1:0]          cdb_fu_out
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [AR_SIZE-1:0] tag_mem_q [FU_ARRAY][FIFO_DEPTH];
    logic [31:0]        val_mem_q [FU_ARRAY][FIFO_DEPTH];
    logic [PW-1:0]      wptr_q    [FU_ARRAY];
    logic [PW-1:0]      rptr_q    [FU_ARRAY];
    logic [CW-1:0]      count_q   [FU_ARRAY];
    logic [CW-1:0]      count_d   [FU_ARRAY];
    logic [FU_SIZE-1:0] rr_q, rr_d;

    logic               valid_q;
    logic [AR_SIZE-1:0] tag_q;
    logic [31:0]        value_q;
    logic [FU_SIZE-1:0] fu_q;

    logic [FU_ARRAY-1:0] ready;
    logic [FU_ARRAY-1:0] nonempty;
    logic [FU_ARRAY-1:0] push;
    logic [FU_ARRAY-1:0] pop;
    logic                grant;
    logic [FU_SIZE-1:0]  gnt_idx;

    // Inputs are below 2*FU_ARRAY, so one conditional subtract is a full modulo.
    function automatic logic [FU_SIZE-1:0] wrap_idx(input int v);
        return (v >= FU_ARRAY) ? FU_SIZE'(v - FU_ARRAY) : FU_SIZE'(v);
    endfunction

    // Ready comes from registered occupancy only, never from this cycle's grant.
    always_comb begin
        for (int i = 0; i < FU_ARRAY; i++) begin
            ready[i]    = count_q[i] < CW'(FIFO_DEPTH);
            nonempty[i] = count_q[i] != '0;
            push[i]     = fu_valid_in[i] && ready[i] && !flush_in &&
                          (fu_tag_in[i*AR_SIZE +: AR_SIZE] != '0);
        end
    end

    // Scan from the farthest offset down so the closest non-empty FU wins.
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        if (!cdb_hold_in && !flush_in) begin
            for (int k = FU_ARRAY - 1; k >= 0; k--) begin
                if (nonempty[wrap_idx(int'(rr_q) + k)]) begin
                    grant   = 1'b1;
                    gnt_idx = wrap_idx(int'(rr_q) + k);
                end
            end
        end
        rr_d = grant ? wrap_idx(int'(gnt_idx) + 1) : rr_q;
    end

    always_comb begin
        for (int i = 0; i < FU_ARRAY; i++) begin
            pop[i] = grant && (gnt_idx == FU_SIZE'(i));
            case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CW'(1);
                2'b01:   count_d[i] = count_q[i] - CW'(1);
                default: count_d[i] = count_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FU_ARRAY; i++) begin
                count_q[i] <= '0;
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
            end
            rr_q    <= '0;
            valid_q <= 1'b0;
            tag_q   <= '0;
            value_q <= '0;
            fu_q    <= '0;
        end else if (flush_in) begin
            for (int i = 0; i < FU_ARRAY; i++) begin
                count_q[i] <= '0;
                wptr_q[i]  <= '0;
                rptr_q[i]  <= '0;
            end
            rr_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < FU_ARRAY; i++) begin
                count_q[i] <= count_d[i];
                if (push[i]) wptr_q[i] <= wptr_q[i] + PW'(1);
                if (pop[i])  rptr_q[i] <= rptr_q[i] + PW'(1);
            end
            rr_q    <= rr_d;
            valid_q <= grant;
            if (grant) begin
                tag_q   <= tag_mem_q[gnt_idx][rptr_q[gnt_idx]];
                value_q <= val_mem_q[gnt_idx][rptr_q[gnt_idx]];
                fu_q    <= gnt_idx;
            end
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FU_ARRAY; i++) begin
            if (push[i]) begin
                tag_mem_q[i][wptr_q[i]] <= fu_tag_in[i*AR_SIZE +: AR_SIZE];
                val_mem_q[i][wptr_q[i]] <= fu_value_in[i*32 +: 32];
            end
        end
    end

    assign fu_ready_out  = ready;
    assign cdb_valid_out = valid_q;
    assign reg_tag_out   = tag_q;
    assign reg_value_out = value_q;
    assign cdb_fu_out    = fu_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int NFU   = 3;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic [2:0]  fu_valid_in;
    logic [20:0] fu_tag_in;
    logic [95:0] fu_value_in;
    logic [2:0]  fu_ready_out;
    logic        cdb_hold_in;
    logic        flush_in;
    logic        cdb_valid_out;
    logic [6:0]  reg_tag_out;
    logic [31:0] reg_value_out;
    logic [1:0]  cdb_fu_out;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [38:0] m_fifo [NFU][$];
    int          m_rr;
    logic        m_valid;
    logic [6:0]  m_tag;
    logic [31:0] m_value;
    logic [1:0]  m_fu;

    cdb_arbiter dut (
        .clk          (clk),
        .rstn         (rstn),
        .fu_valid_in  (fu_valid_in),
        .fu_tag_in    (fu_tag_in),
        .fu_value_in  (fu_value_in),
        .fu_ready_out (fu_ready_out),
        .cdb_hold_in  (cdb_hold_in),
        .flush_in     (flush_in),
        .cdb_valid_out(cdb_valid_out),
        .reg_tag_out  (reg_tag_out),
        .reg_value_out(reg_value_out),
        .cdb_fu_out   (cdb_fu_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NFU; i++) m_fifo[i].delete();
        m_rr    = 0;
        m_valid = 1'b0;
        m_tag   = '0;
        m_value = '0;
        m_fu    = '0;
    endtask

    function automatic logic [2:0] model_ready();
        logic [2:0] r;
        for (int i = 0; i < NFU; i++) r[i] = m_fifo[i].size() < DEPTH;
        return r;
    endfunction

    // One clock edge of the abstract behaviour, using the inputs as driven now.
    task automatic model_step();
        logic [2:0]  rdy;
        logic [38:0] e;
        int          g;
        rdy = model_ready();
        if (flush_in) begin
            for (int i = 0; i < NFU; i++) m_fifo[i].delete();
            m_rr    = 0;
            m_valid = 1'b0;
            return;
        end
        g = -1;
        if (!cdb_hold_in)
            for (int k = 0; k < NFU; k++)
                if (g < 0 && m_fifo[(m_rr + k) % NFU].size() > 0) g = (m_rr + k) % NFU;
        if (g >= 0) begin
            e       = m_fifo[g].pop_front();
            m_tag   = e[38:32];
            m_value = e[31:0];
            m_fu    = 2'(g);
            m_valid = 1'b1;
            m_rr    = (g + 1) % NFU;
        end else begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < NFU; i++)
            if (fu_valid_in[i] && rdy[i] && fu_tag_in[i*7 +: 7] != 7'd0)
                m_fifo[i].push_back({fu_tag_in[i*7 +: 7], fu_value_in[i*32 +: 32]});
    endtask

    task automatic tick();
        check("ready", 64'(fu_ready_out), 64'(model_ready()));
        model_step();
        @(posedge clk);
        @(negedge clk);
        check("valid", 64'(cdb_valid_out), 64'(m_valid));
        check("tag",   64'(reg_tag_out),   64'(m_tag));
        check("value", 64'(reg_value_out), 64'(m_value));
        check("fu",    64'(cdb_fu_out),    64'(m_fu));
    endtask

    task automatic clear_in();
        fu_valid_in = '0;
        fu_tag_in   = '0;
        fu_value_in = '0;
        cdb_hold_in = 1'b0;
        flush_in    = 1'b0;
    endtask

    task automatic drive(input int fu, input logic [6:0] tag, input logic [31:0] val);
        fu_valid_in[fu]        = 1'b1;
        fu_tag_in[fu*7 +: 7]   = tag;
        fu_value_in[fu*32 +: 32] = val;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_valid", 64'(cdb_valid_out), 64'd0);
        check("rst_tag",   64'(reg_tag_out),   64'd0);
        check("rst_value", 64'(reg_value_out), 64'd0);
        check("rst_fu",    64'(cdb_fu_out),    64'd0);
        check("rst_ready", 64'(fu_ready_out),  64'h7);
        model_reset();
        clear_in();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b1;
        clear_in();
        model_reset();
        @(negedge clk);
        do_reset();
        tick();
        tick();

        // single result, 2-edge latency
        drive(1, 7'd5, 32'hDEADBEEF);
        tick();
        clear_in();
        tick();
        check("single_valid", 64'(cdb_valid_out), 64'd1);
        check("single_tag",   64'(reg_tag_out),   64'd5);
        check("single_value", 64'(reg_value_out), 64'hDEADBEEF);
        check("single_fu",    64'(cdb_fu_out),    64'd1);
        tick();
        check("single_drop", 64'(cdb_valid_out), 64'd0);

        // contention from reset, then FU2+FU0 burst
        do_reset();
        drive(0, 7'd10, 32'h100);
        drive(1, 7'd11, 32'h101);
        drive(2, 7'd12, 32'h102);
        tick();
        clear_in();
        for (int k = 0; k < 3; k++) begin
            tick();
            check("rr_order_fu",  64'(cdb_fu_out),  64'(k));
            check("rr_order_tag", 64'(reg_tag_out), 64'(10 + k));
        end
        drive(2, 7'd22, 32'h22);
        drive(0, 7'd20, 32'h20);
        tick();
        clear_in();
        tick();
        check("burst_first", 64'(cdb_fu_out), 64'd0);
        tick();
        check("burst_second", 64'(cdb_fu_out), 64'd2);
        tick();

        // backpressure under hold
        cdb_hold_in = 1'b1;
        for (int t = 1; t <= 3; t++) begin
            fu_valid_in = '0;
            drive(0, 7'(t), 32'(t));
            tick();
            if (t == 2) check("bp_ready0_low", 64'(fu_ready_out[0]), 64'd0);
        end
        clear_in();
        tick();
        check("bp_first", 64'(reg_tag_out), 64'd1);
        drive(0, 7'd3, 32'd3);
        tick();
        check("bp_second", 64'(reg_tag_out), 64'd2);
        clear_in();
        tick();
        check("bp_third", 64'(reg_tag_out), 64'd3);
        tick();

        // x0 accepted but never broadcast
        drive(1, 7'd0, 32'h55);
        tick();
        clear_in();
        tick();
        check("x0_none", 64'(cdb_valid_out), 64'd0);

        // flush with two buffered and a concurrent FU2 enqueue
        cdb_hold_in = 1'b1;
        drive(0, 7'd30, 32'h30);
        drive(1, 7'd31, 32'h31);
        tick();
        clear_in();
        flush_in = 1'b1;
        drive(2, 7'd32, 32'h32);
        tick();
        check("flush_valid", 64'(cdb_valid_out), 64'd0);
        clear_in();
        tick();
        tick();
        check("flush_empty", 64'(cdb_valid_out), 64'd0);
        drive(2, 7'd40, 32'h40);
        drive(0, 7'd41, 32'h41);
        tick();
        clear_in();
        tick();
        check("flush_rr0", 64'(cdb_fu_out), 64'd0);
        tick();
        tick();

        // enqueue attempt and pop on a full FIFO in the same cycle
        cdb_hold_in = 1'b1;
        drive(0, 7'd50, 32'h50);
        tick();
        drive(0, 7'd51, 32'h51);
        tick();
        cdb_hold_in = 1'b0;
        drive(0, 7'd52, 32'h52);
        tick();
        check("full_pop_ready", 64'(fu_ready_out[0]), 64'd1);
        clear_in();
        tick();
        check("full_pop_last", 64'(reg_tag_out), 64'd51);
        tick();
        check("full_pop_empty", 64'(cdb_valid_out), 64'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            fu_valid_in = 3'($urandom_range(0, 7));
            for (int i = 0; i < NFU; i++) begin
                fu_tag_in[i*7 +: 7]      = ($urandom_range(0, 9) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
                fu_value_in[i*32 +: 32]  = $urandom;
            end
            cdb_hold_in = ($urandom_range(0, 9) == 0);
            flush_in    = ($urandom_range(0, 49) == 0);
            tick();
        end
        clear_in();
        for (int c = 0; c < 8; c++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
